period_phase_normalizer: RTL and testbench



---
 rtl/period_phase_normalizer.sv | 183 ++++++++++++++++++
 tb/tb_period_phase_normalizer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/period_phase_normalizer.sv
// Phase normalizer that sits behind the reciprocal frequency counter.
// It turns the raw V-I phase count into a fraction of the voltage period with a
// bit-serial restoring divider. Each result goes out as a 3-beat AXI-Stream
// record: period_v, flags+fraction, period_i (tlast).
module period_phase_normalizer #(
  parameter int COUNT_WIDTH      = 32,
  parameter int FRAC_BITS        = 16,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COUNT_WIDTH-1:0]      period_v,
  input  logic [COUNT_WIDTH-1:0]      period_i,
  input  logic [COUNT_WIDTH-1:0]      phase_cnt,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  output logic                        busy,
  output logic [15:0]                 dropped_cnt
);

  localparam int IW = $clog2(FRAC_BITS + 1);

  typedef enum logic [1:0] {IDLE, DIV, EMIT} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] prev_v, prev_i, prev_ph;
  logic [COUNT_WIDTH-1:0] snap_v, snap_i, snap_ph;
  logic [COUNT_WIDTH-1:0] pend_v, pend_i, pend_ph;
  logic                   pending;
  logic [COUNT_WIDTH:0]   rem;
  logic [FRAC_BITS-1:0]   frac;
  logic                   sat, div_zero;
  logic [1:0]             beat;
  logic [IW-1:0]          iter;

  logic                   change, final_acc, load_en;
  logic [COUNT_WIDTH-1:0] ld_v, ld_i, ld_ph;
  logic [COUNT_WIDTH:0]   rem_sh, rem_nx;
  logic                   ge;

  assign busy = (state != IDLE);

  // Input change detection against last cycle's inputs, plus snapshot source select.
  always_comb begin
    change    = (period_v != prev_v) || (period_i != prev_i) || (phase_cnt != prev_ph);
    final_acc = (state == EMIT) && M_AXIS_tvalid && M_AXIS_tready && (beat == 2'd2);
    // A change landing on the final-beat cycle with nothing pending is taken
    // straight from the inputs so it is not lost when prev_* catches up.
    load_en   = ((state == IDLE) && change) || (final_acc && (pending || change));
    if ((state == IDLE) || (final_acc && !pending)) begin
      ld_v  = period_v;
      ld_i  = period_i;
      ld_ph = phase_cnt;
    end else begin
      ld_v  = pend_v;
      ld_i  = pend_i;
      ld_ph = pend_ph;
    end
  end

  // One restoring-divider step; the full COUNT_WIDTH+1 compare avoids wrap.
  always_comb begin
    rem_sh = rem << 1;
    ge     = (rem_sh >= {1'b0, snap_v});
    rem_nx = ge ? (rem_sh - {1'b0, snap_v}) : rem_sh;
  end

  // Control FSM, divider datapath, stream outputs and overrun bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      prev_v        <= '0;
      prev_i        <= '0;
      prev_ph       <= '0;
      snap_v        <= '0;
      snap_i        <= '0;
      snap_ph       <= '0;
      pend_v        <= '0;
      pend_i        <= '0;
      pend_ph       <= '0;
      pending       <= 1'b0;
      rem           <= '0;
      frac          <= '0;
      sat           <= 1'b0;
      div_zero      <= 1'b0;
      beat          <= '0;
      iter          <= '0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
      dropped_cnt   <= '0;
    end else begin
      prev_v  <= period_v;
      prev_i  <= period_i;
      prev_ph <= phase_cnt;

      // Changes while busy park in pend_*; overwriting an unconsumed one is a drop.
      if (busy && change) begin
        pend_v  <= period_v;
        pend_i  <= period_i;
        pend_ph <= phase_cnt;
      end
      if (final_acc)
        pending <= pending && change;
      else if (busy && change)
        pending <= 1'b1;
      if (busy && change && pending && !final_acc && (dropped_cnt != 16'hFFFF))
        dropped_cnt <= dropped_cnt + 16'd1;

      case (state)
        IDLE: ;
        DIV: begin
          rem  <= rem_nx;
          frac <= {frac[FRAC_BITS-2:0], ge};
          iter <= iter + IW'(1);
          // Present beat 0 on the same edge as the last step to keep latency tight.
          if (iter == IW'(FRAC_BITS - 1)) begin
            state         <= EMIT;
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata  <= AXIS_TDATA_WIDTH'(snap_v);
            M_AXIS_tlast  <= 1'b0;
            beat          <= 2'd0;
          end
        end
        EMIT: begin
          if (!M_AXIS_tvalid) begin
            // Fast-path entry: snapshot is registered now, put beat 0 out.
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata  <= AXIS_TDATA_WIDTH'(snap_v);
            M_AXIS_tlast  <= 1'b0;
            beat          <= 2'd0;
          end else if (M_AXIS_tready) begin
            case (beat)
              2'd0: begin
                M_AXIS_tdata <= AXIS_TDATA_WIDTH'({div_zero, sat, frac});
                beat         <= 2'd1;
              end
              2'd1: begin
                M_AXIS_tdata <= AXIS_TDATA_WIDTH'(snap_i);
                M_AXIS_tlast <= 1'b1;
                beat         <= 2'd2;
              end
              default: begin
                M_AXIS_tvalid <= 1'b0;
                M_AXIS_tlast  <= 1'b0;
                M_AXIS_tdata  <= '0;
                beat          <= 2'd0;
                state         <= IDLE;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase

      // Snapshot load and branch; overrides the IDLE return above when chaining.
      if (load_en) begin
        snap_v   <= ld_v;
        snap_i   <= ld_i;
        snap_ph  <= ld_ph;
        rem      <= {1'b0, ld_ph};
        iter     <= '0;
        sat      <= 1'b0;
        div_zero <= 1'b0;
        if (ld_v == '0) begin
          frac     <= '0;
          div_zero <= 1'b1;
          state    <= EMIT;
        end else if (ld_ph >= ld_v) begin
          frac  <= '1;
          sat   <= 1'b1;
          state <= EMIT;
        end else begin
          frac  <= '0;
          state <= DIV;
        end
      end
    end
  end

endmodule

// File: tb/tb_period_phase_normalizer.sv
// Directed bench for period_phase_normalizer: stimulus pushes expected beats
// into a scoreboard queue, a negedge monitor pops and compares accepted beats.
module tb_period_phase_normalizer;

  localparam int CW = 32;
  localparam int FB = 16;
  localparam int TW = 32;
  localparam int DIV_LAT  = FB + 1;
  localparam int FAST_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] period_v = '0, period_i = '0, phase_cnt = '0;
  logic [TW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tvalid, M_AXIS_tready, M_AXIS_tlast, busy;
  logic [15:0]   dropped_cnt;

  typedef struct { logic [TW-1:0] data; logic last; } beat_t;
  beat_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  period_phase_normalizer #(.COUNT_WIDTH(CW), .FRAC_BITS(FB), .AXIS_TDATA_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .period_v(period_v), .period_i(period_i), .phase_cnt(phase_cnt),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tlast(M_AXIS_tlast),
    .busy(busy), .dropped_cnt(dropped_cnt)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rec(input logic [TW-1:0] b0, input logic [TW-1:0] b1, input logic [TW-1:0] b2);
    beat_t e;
    e.data = b0; e.last = 1'b0; sb.push_back(e);
    e.data = b1; e.last = 1'b0; sb.push_back(e);
    e.data = b2; e.last = 1'b1; sb.push_back(e);
  endtask

  task automatic apply(input logic [CW-1:0] v, input logic [CW-1:0] i, input logic [CW-1:0] ph);
    @(posedge clk); #1;
    period_v = v; period_i = i; phase_cnt = ph;
  endtask

  // Counts edges from the input change until tvalid is seen high.
  task automatic wait_valid(input string name, input int exp);
    int k = 0;
    while (!M_AXIS_tvalid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(k), 64'(exp));
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || sb.size() != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(k < 300), 64'd1);
  endtask

  // Monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst && M_AXIS_tvalid && M_AXIS_tready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(M_AXIS_tdata), 64'hDEAD_0000_0000);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", 64'(M_AXIS_tdata), 64'(e.data));
        check("beat_last", 64'(M_AXIS_tlast), 64'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad, lasts, idle_seen;
    M_AXIS_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid",  64'(M_AXIS_tvalid), 64'd0);
    check("rst_tlast",   64'(M_AXIS_tlast),  64'd0);
    check("rst_tdata",   64'(M_AXIS_tdata),  64'd0);
    check("rst_busy",    64'(busy),          64'd0);
    check("rst_dropped", 64'(dropped_cnt),   64'd0);
    rst = 1'b1;

    // Normal division: 250/1000 -> 0x4000
    push_rec(32'd1000, 32'h0000_4000, 32'd1002);
    apply(32'd1000, 32'd1002, 32'd250);
    wait_valid("norm_latency", DIV_LAT);
    check("norm_busy", 64'(busy), 64'd1);
    wait_idle("norm_drain");

    // Saturation: phase == period
    push_rec(32'd1000, 32'h0001_FFFF, 32'd1001);
    apply(32'd1000, 32'd1001, 32'd1000);
    wait_valid("sat_latency", FAST_LAT);
    wait_idle("sat_drain");

    // Divide by zero
    push_rec(32'd0, 32'h0002_0000, 32'd7);
    apply(32'd0, 32'd7, 32'd5);
    wait_valid("dz_latency", FAST_LAT);
    wait_idle("dz_drain");

    // Backpressure on beat1: 1/3 -> 0x5555
    push_rec(32'd3, 32'h0000_5555, 32'd4);
    M_AXIS_tready = 1'b0;
    apply(32'd3, 32'd4, 32'd1);
    wait_valid("bp_latency", DIV_LAT);
    M_AXIS_tready = 1'b1;
    @(posedge clk); #1;
    M_AXIS_tready = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (M_AXIS_tdata !== 32'h0000_5555 || M_AXIS_tvalid !== 1'b1 || M_AXIS_tlast !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("bp_hold_cycles_bad", 64'(bad), 64'd0);
    M_AXIS_tready = 1'b1;
    @(posedge clk); #1;
    check("bp_beat2_next", 64'({M_AXIS_tvalid, M_AXIS_tlast}), 64'b11);
    @(posedge clk); #1;
    check("bp_done_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    wait_idle("bp_drain");

    // Overrun: three changes while busy, only the last survives
    M_AXIS_tready = 1'b0;
    push_rec(32'd200, 32'h0000_4000, 32'd201);
    apply(32'd200, 32'd201, 32'd50);
    repeat (2) @(posedge clk);
    apply(32'd400, 32'd401, 32'd100);
    repeat (2) @(posedge clk);
    apply(32'd500, 32'd501, 32'd125);
    repeat (2) @(posedge clk);
    apply(32'd800, 32'd801, 32'd600);
    push_rec(32'd800, 32'h0000_C000, 32'd801);
    @(posedge clk); #1;
    check("ovr_dropped", 64'(dropped_cnt), 64'd2);
    M_AXIS_tready = 1'b1;
    lasts = 0; idle_seen = 0;
    for (int c = 0; c < 200 && lasts < 2; c++) begin
      @(negedge clk);
      if (!busy) idle_seen++;
      if (M_AXIS_tvalid && M_AXIS_tready && M_AXIS_tlast) lasts++;
    end
    check("ovr_records", 64'(lasts), 64'd2);
    check("ovr_idle_gap", 64'(idle_seen), 64'd0);
    wait_idle("ovr_drain");

    // Reset mid-DIV aborts; current inputs then re-trigger, then a fresh change
    apply(32'd1000, 32'd9, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("mid_div_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mrst_tvalid",  64'(M_AXIS_tvalid), 64'd0);
    check("mrst_tdata",   64'(M_AXIS_tdata),  64'd0);
    check("mrst_tlast",   64'(M_AXIS_tlast),  64'd0);
    check("mrst_busy",    64'(busy),          64'd0);
    check("mrst_dropped", 64'(dropped_cnt),   64'd0);
    push_rec(32'd1000, 32'h0000_0041, 32'd9);
    wait_valid("post_rst_latency", DIV_LAT);
    wait_idle("post_rst_drain");
    push_rec(32'd1024, 32'h0000_4000, 32'd1000);
    apply(32'd1024, 32'd1000, 32'd256);
    wait_valid("clean_latency", DIV_LAT);
    wait_idle("clean_drain");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
